cpu_mem_bridge: RTL and testbench

- Memory responder for the cpu_2432 core.
- Serves the core's instruction-fetch port and data port from a single byte-wide synchronous SRAM.
- Drives the core's clock enable so that each core cycle advances only after its fetch and data access are complete.
- Sits between cpu_2432 and the board SRAM; it is the only agent on the SRAM bus.

---
 rtl/cpu_mem_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - byte-serial SRAM responder for the cpu_2432 fetch and data ports
module cpu_mem_bridge #(
    parameter int                 SRAM_AW   = 20,
    parameter logic [SRAM_AW-1:0] IMEM_BASE = 20'h00000,
    parameter logic [SRAM_AW-1:0] DMEM_BASE = 20'h40000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [23:0]        i_iaddr,
    input  logic [23:0]        i_daddr,
    input  logic [31:0]        i_dout,
    input  logic               i_ram_rd,
    input  logic               i_ram_wr,
    output logic [23:0]        o_instr,
    output logic [31:0]        o_din,
    output logic               o_clk_en,
    output logic [SRAM_AW-1:0] o_sram_addr,
    output logic [7:0]         o_sram_dout,
    output logic               o_sram_we,
    input  logic [7:0]         i_sram_din,
    output logic               o_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IFETCH,
        S_DWR,
        S_DRD,
        S_DRAIN,
        S_STEP
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [23:0]        iaddr_q, iaddr_d;
    logic [23:0]        daddr_q, daddr_d;
    logic [31:0]        dout_q, dout_d;
    logic               rd_q, rd_d;
    logic               wr_q, wr_d;
    logic [23:0]        ibuf_q, ibuf_d;
    logic [31:0]        rbuf_q, rbuf_d;
    logic [23:0]        instr_q, instr_d;
    logic [31:0]        din_q, din_d;
    logic               clk_en_q, clk_en_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [7:0]         sram_dout_q, sram_dout_d;
    logic               sram_we_q, sram_we_d;
    logic               err_q, err_d;

    function automatic logic [SRAM_AW-1:0] byte_addr(input logic [SRAM_AW-1:0] base,
                                                     input logic [23:0]        word,
                                                     input logic [1:0]         k);
        return base + SRAM_AW'({word, 2'b00}) + SRAM_AW'(k);
    endfunction

    // Every address is registered one cycle ahead of the state that owns it,
    // so each SRAM byte lands in i_sram_din during the following state's cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        iaddr_d     = iaddr_q;
        daddr_d     = daddr_q;
        dout_d      = dout_q;
        rd_d        = rd_q;
        wr_d        = wr_q;
        ibuf_d      = ibuf_q;
        rbuf_d      = rbuf_q;
        instr_d     = instr_q;
        din_d       = din_q;
        clk_en_d    = 1'b0;
        sram_addr_d = sram_addr_q;
        sram_dout_d = sram_dout_q;
        sram_we_d   = 1'b0;
        err_d       = err_q;
        case (state_q)
            S_IDLE, S_STEP: begin
                if (state_q == S_STEP && rd_q) begin
                    din_d = rbuf_q;
                end
                iaddr_d     = i_iaddr;
                daddr_d     = i_daddr;
                dout_d      = i_dout;
                rd_d        = i_ram_rd & ~i_ram_wr;
                wr_d        = i_ram_wr;
                err_d       = err_q | (i_ram_rd & i_ram_wr);
                sram_addr_d = byte_addr(IMEM_BASE, i_iaddr, 2'd0);
                cnt_d       = 2'd0;
                state_d     = S_IFETCH;
            end
            S_IFETCH: begin
                if (cnt_q == 2'd1) ibuf_d[7:0]  = i_sram_din;
                if (cnt_q == 2'd2) ibuf_d[15:8] = i_sram_din;
                if (cnt_q != 2'd2) begin
                    cnt_d       = cnt_q + 2'd1;
                    sram_addr_d = byte_addr(IMEM_BASE, iaddr_q, cnt_q + 2'd1);
                end else begin
                    cnt_d = 2'd0;
                    if (wr_q) begin
                        state_d     = S_DWR;
                        sram_addr_d = byte_addr(DMEM_BASE, daddr_q, 2'd0);
                        sram_dout_d = dout_q[7:0];
                        sram_we_d   = 1'b1;
                    end else if (rd_q) begin
                        state_d     = S_DRD;
                        sram_addr_d = byte_addr(DMEM_BASE, daddr_q, 2'd0);
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DWR: begin
                if (cnt_q == 2'd0) ibuf_d[23:16] = i_sram_din;
                if (cnt_q != 2'd3) begin
                    cnt_d       = cnt_q + 2'd1;
                    sram_addr_d = byte_addr(DMEM_BASE, daddr_q, cnt_q + 2'd1);
                    sram_dout_d = dout_q[{cnt_q + 2'd1, 3'b000} +: 8];
                    sram_we_d   = 1'b1;
                end else begin
                    cnt_d    = 2'd0;
                    state_d  = S_STEP;
                    clk_en_d = 1'b1;
                    instr_d  = ibuf_q;
                end
            end
            S_DRD: begin
                if (cnt_q == 2'd0) begin
                    ibuf_d[23:16] = i_sram_din;
                end else begin
                    rbuf_d[{cnt_q - 2'd1, 3'b000} +: 8] = i_sram_din;
                end
                if (cnt_q != 2'd3) begin
                    cnt_d       = cnt_q + 2'd1;
                    sram_addr_d = byte_addr(DMEM_BASE, daddr_q, cnt_q + 2'd1);
                end else begin
                    cnt_d   = 2'd0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (rd_q) begin
                    rbuf_d[31:24] = i_sram_din;
                end else begin
                    ibuf_d[23:16] = i_sram_din;
                end
                state_d  = S_STEP;
                clk_en_d = 1'b1;
                instr_d  = ibuf_d;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 2'd0;
            iaddr_q     <= 24'd0;
            daddr_q     <= 24'd0;
            dout_q      <= 32'd0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            ibuf_q      <= 24'd0;
            rbuf_q      <= 32'd0;
            instr_q     <= 24'd0;
            din_q       <= 32'd0;
            clk_en_q    <= 1'b0;
            sram_addr_q <= '0;
            sram_dout_q <= 8'd0;
            sram_we_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            iaddr_q     <= iaddr_d;
            daddr_q     <= daddr_d;
            dout_q      <= dout_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            ibuf_q      <= ibuf_d;
            rbuf_q      <= rbuf_d;
            instr_q     <= instr_d;
            din_q       <= din_d;
            clk_en_q    <= clk_en_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
            sram_we_q   <= sram_we_d;
            err_q       <= err_d;
        end
    end

    assign o_instr     = instr_q;
    assign o_din       = din_q;
    assign o_clk_en    = clk_en_q;
    assign o_sram_addr = sram_addr_q;
    assign o_sram_dout = sram_dout_q;
    assign o_sram_we   = sram_we_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb/tb_cpu_mem_bridge.sv - randomized self-checking bench for cpu_mem_bridge
module tb_cpu_mem_bridge;

    localparam int          AW   = 20;
    localparam int unsigned IMEM = 32'h00000;
    localparam int unsigned DMEM = 32'h40000;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] iaddr, daddr;
    logic [31:0] dout;
    logic        rd, wr;
    logic [23:0] o_instr;
    logic [31:0] o_din;
    logic        o_clk_en;
    logic [19:0] o_sram_addr;
    logic [7:0]  o_sram_dout;
    logic        o_sram_we;
    logic [7:0]  rd_data;
    logic        o_err;

    int vectors = 0;
    int miscompares = 0;

    cpu_mem_bridge #(.SRAM_AW(AW), .IMEM_BASE(20'h00000), .DMEM_BASE(20'h40000)) dut (
        .i_clk(clk), .i_rst(rst), .i_iaddr(iaddr), .i_daddr(daddr), .i_dout(dout),
        .i_ram_rd(rd), .i_ram_wr(wr), .o_instr(o_instr), .o_din(o_din), .o_clk_en(o_clk_en),
        .o_sram_addr(o_sram_addr), .o_sram_dout(o_sram_dout), .o_sram_we(o_sram_we),
        .i_sram_din(rd_data), .o_err(o_err)
    );

    always #5 clk = ~clk;

    logic [7:0]  sram    [0:(1<<AW)-1];
    logic [7:0]  ref_mem [0:(1<<AW)-1];
    logic [31:0] ref_din;
    logic        ref_err;
    logic [19:0] wlog_a[$];
    logic [7:0]  wlog_d[$];
    logic [19:0] exp_a[$];
    logic [7:0]  exp_d[$];

    always @(posedge clk) begin
        rd_data <= sram[o_sram_addr];
        if (o_sram_we) sram[o_sram_addr] <= o_sram_dout;
    end

    always @(posedge clk) begin
        if (o_sram_we) begin
            wlog_a.push_back(o_sram_addr);
            wlog_d.push_back(o_sram_dout);
        end
    end

    function automatic logic [19:0] wrap_addr(input int unsigned base, input logic [23:0] word, input int k);
        longint s;
        s = longint'(base) + longint'(word) * 4 + longint'(k);
        return 20'(s % (longint'(1) << AW));
    endfunction

    task automatic do_reset();
        rst = 1'b1; iaddr = '0; daddr = '0; dout = '0; rd = 1'b0; wr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_din = '0;
        ref_err = 1'b0;
    endtask

    // One core cycle: the reference predicts, then the request is driven until the next STEP.
    task automatic core_cycle(input logic [23:0] ia, input logic [23:0] da, input logic [31:0] dv,
                              input logic r, input logic w,
                              output int per, output logic [23:0] ins, output logic [31:0] dn, output logic er,
                              output int eper, output logic [23:0] eins, output logic [31:0] edn, output logic eer);
        int n;
        logic [19:0] a;
        logic [31:0] ld;
        eper = w ? 8 : (r ? 9 : 5);
        for (int k = 0; k < 3; k++) eins[8*k +: 8] = ref_mem[wrap_addr(IMEM, ia, k)];
        edn = ref_din;
        ref_err = ref_err | (r & w);
        eer = ref_err;
        exp_a.delete(); exp_d.delete();
        if (w) begin
            for (int k = 0; k < 4; k++) begin
                a = wrap_addr(DMEM, da, k);
                exp_a.push_back(a);
                exp_d.push_back(dv[8*k +: 8]);
                ref_mem[a] = dv[8*k +: 8];
            end
        end else if (r) begin
            for (int k = 0; k < 4; k++) ld[8*k +: 8] = ref_mem[wrap_addr(DMEM, da, k)];
            ref_din = ld;
        end
        wlog_a.delete(); wlog_d.delete();
        iaddr = ia; daddr = da; dout = dv; rd = r; wr = w;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_clk_en && n < 40);
        per = n; ins = o_instr; dn = o_din; er = o_err;
    endtask

    task automatic test_reset();
        rst = 1'b1; iaddr = '0; daddr = '0; dout = '0; rd = 1'b0; wr = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({o_instr, o_din, o_clk_en, o_sram_addr, o_sram_dout, o_sram_we, o_err} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got instr=%h din=%h en=%b addr=%h dout=%h we=%b err=%b want all zero",
                     o_instr, o_din, o_clk_en, o_sram_addr, o_sram_dout, o_sram_we, o_err);
        end
    endtask

    task automatic test_fetch();
        int per, eper; logic [23:0] ins, eins; logic [31:0] dn, edn; logic er, eer;
        sram[0] = 8'h56; sram[1] = 8'h34; sram[2] = 8'h12;
        ref_mem[0] = 8'h56; ref_mem[1] = 8'h34; ref_mem[2] = 8'h12;
        do_reset();
        core_cycle(24'h0, 24'h0, 32'h0, 1'b0, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (per !== 5) begin miscompares++; $display("FAIL fetch_first_pulse got %0d want 5", per); end
        vectors++;
        if (ins !== 24'h123456) begin miscompares++; $display("FAIL fetch_instr got %h want 123456", ins); end
        core_cycle(24'h0, 24'h0, 32'h0, 1'b0, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (per !== 5) begin miscompares++; $display("FAIL fetch_period got %0d want 5", per); end
    endtask

    task automatic test_store_load();
        int per, eper; logic [23:0] ins, eins; logic [31:0] dn, edn; logic er, eer;
        logic [7:0] bytes [4];
        bytes[0] = 8'hEF; bytes[1] = 8'hBE; bytes[2] = 8'hAD; bytes[3] = 8'hDE;
        core_cycle(24'h1, 24'h10, 32'hDEADBEEF, 1'b0, 1'b1, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (per !== 8) begin miscompares++; $display("FAIL store_period got %0d want 8", per); end
        vectors++;
        if (wlog_a.size() != 4) begin
            miscompares++; $display("FAIL store_count got %0d want 4", wlog_a.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (wlog_a[k] !== 20'h40040 + 20'(k) || wlog_d[k] !== bytes[k]) begin
                    miscompares++;
                    $display("FAIL store_byte%0d got %h:%h want %h:%h", k, wlog_a[k], wlog_d[k], 20'h40040 + 20'(k), bytes[k]);
                end
            end
        end
        vectors++;
        if (ins !== eins) begin miscompares++; $display("FAIL store_instr got %h want %h", ins, eins); end
        core_cycle(24'h2, 24'h10, 32'h0, 1'b1, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (per !== 9) begin miscompares++; $display("FAIL load_period got %0d want 9", per); end
        vectors++;
        if (dn !== 32'h0) begin miscompares++; $display("FAIL load_din_early got %h want 0", dn); end
        core_cycle(24'h3, 24'h0, 32'h0, 1'b0, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (dn !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load_din got %h want deadbeef", dn); end
        vectors++;
        if (er !== 1'b0) begin miscompares++; $display("FAIL store_load_err got %b want 0", er); end
    endtask

    task automatic test_wrap();
        int per, eper; logic [23:0] ins, eins; logic [31:0] dn, edn; logic er, eer;
        sram[20'hFFFFC] = 8'h9A; sram[20'hFFFFD] = 8'hBC; sram[20'hFFFFE] = 8'hDE; sram[20'hFFFFF] = 8'h77;
        ref_mem[20'hFFFFC] = 8'h9A; ref_mem[20'hFFFFD] = 8'hBC; ref_mem[20'hFFFFE] = 8'hDE; ref_mem[20'hFFFFF] = 8'h77;
        core_cycle(24'h3FFFFF, 24'h02FFFF, 32'h0, 1'b1, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (ins !== 24'hDEBC9A) begin miscompares++; $display("FAIL wrap_instr got %h want debc9a", ins); end
        core_cycle(24'h0, 24'h03FFFF, 32'h01020304, 1'b0, 1'b1, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (dn !== 32'h77DEBC9A) begin miscompares++; $display("FAIL wrap_load got %h want 77debc9a", dn); end
        vectors++;
        if (wlog_a.size() != 4 || wlog_a[0] !== 20'h3FFFC || wlog_a[3] !== 20'h3FFFF) begin
            miscompares++;
            $display("FAIL wrap_store_addr got n=%0d first=%h want n=4 first=3fffc", wlog_a.size(), wlog_a.size() ? wlog_a[0] : 20'h0);
        end
    endtask

    task automatic test_rd_wr_err();
        int per, eper; logic [23:0] ins, eins; logic [31:0] dn, edn; logic er, eer;
        core_cycle(24'h5, 24'h50, 32'hCAFEF00D, 1'b1, 1'b1, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (per !== 8 || wlog_a.size() != 4) begin
            miscompares++; $display("FAIL rdwr_write got period=%0d writes=%0d want 8 and 4", per, wlog_a.size());
        end
        vectors++;
        if (er !== 1'b1) begin miscompares++; $display("FAIL rdwr_err got %b want 1", er); end
        core_cycle(24'h6, 24'h50, 32'h0, 1'b0, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (er !== 1'b1 || dn !== 32'h77DEBC9A) begin
            miscompares++; $display("FAIL rdwr_sticky got err=%b din=%h want 1 77debc9a", er, dn);
        end
        core_cycle(24'h7, 24'h50, 32'h0, 1'b1, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        core_cycle(24'h8, 24'h0, 32'h0, 1'b0, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (dn !== 32'hCAFEF00D || er !== 1'b1) begin
            miscompares++; $display("FAIL rdwr_readback got din=%h err=%b want cafef00d 1", dn, er);
        end
        do_reset();
        vectors++;
        if (o_err !== 1'b0) begin miscompares++; $display("FAIL rdwr_err_clear got %b want 0", o_err); end
    endtask

    task automatic test_reset_mid_write();
        int n, per, eper; logic [23:0] ins, eins; logic [31:0] dn, edn; logic er, eer;
        logic [19:0] a0;
        core_cycle(24'h0, 24'h0, 32'h0, 1'b0, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        a0 = wrap_addr(DMEM, 24'h30, 0);
        for (int k = 0; k < 4; k++) begin sram[a0 + 20'(k)] = 8'hAA; ref_mem[a0 + 20'(k)] = 8'hAA; end
        wlog_a.delete(); wlog_d.delete();
        iaddr = 24'h0; daddr = 24'h30; dout = 32'h11223344; rd = 1'b0; wr = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!o_sram_we && n < 20);
        vectors++;
        if (o_sram_we !== 1'b1 || o_sram_addr !== a0 || o_sram_dout !== 8'h44) begin
            miscompares++; $display("FAIL rstw_first_byte got we=%b addr=%h dout=%h want 1 %h 44", o_sram_we, o_sram_addr, o_sram_dout, a0);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (o_sram_we !== 1'b0 || o_din !== 32'h0) begin
            miscompares++; $display("FAIL rstw_we_drop got we=%b din=%h want 0 0", o_sram_we, o_din);
        end
        repeat (4) @(negedge clk);
        vectors++;
        if (wlog_a.size() != 1 || sram[a0] !== 8'h44 || sram[a0+1] !== 8'hAA || sram[a0+2] !== 8'hAA || sram[a0+3] !== 8'hAA) begin
            miscompares++;
            $display("FAIL rstw_partial got writes=%0d bytes=%h %h %h %h want 1 44 aa aa aa", wlog_a.size(), sram[a0], sram[a0+1], sram[a0+2], sram[a0+3]);
        end
        ref_mem[a0] = 8'h44; ref_din = '0; ref_err = 1'b0;
        rst = 1'b0;
        core_cycle(24'h0, 24'h0, 32'h0, 1'b0, 1'b0, per, ins, dn, er, eper, eins, edn, eer);
        vectors++;
        if (per !== 5 || dn !== 32'h0) begin
            miscompares++; $display("FAIL rstw_restart got period=%0d din=%h want 5 0", per, dn);
        end
    endtask

    task automatic test_random();
        int per, eper, mode; logic [23:0] ins, eins; logic [31:0] dn, edn; logic er, eer;
        logic [23:0] ia, da, last_da;
        last_da = 24'h0;
        for (int t = 0; t < 40; t++) begin
            mode = int'($urandom_range(0, 4));
            ia = ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom);
            da = ($urandom_range(0, 1) == 0) ? last_da : 24'($urandom);
            last_da = da;
            core_cycle(ia, da, $urandom, mode == 2 || mode == 4, mode >= 3,
                       per, ins, dn, er, eper, eins, edn, eer);
            vectors++;
            if (per !== eper) begin miscompares++; $display("FAIL rand_period[%0d] got %0d want %0d", t, per, eper); end
            vectors++;
            if (ins !== eins) begin miscompares++; $display("FAIL rand_instr[%0d] got %h want %h", t, ins, eins); end
            vectors++;
            if (dn !== edn) begin miscompares++; $display("FAIL rand_din[%0d] got %h want %h", t, dn, edn); end
            vectors++;
            if (er !== eer) begin miscompares++; $display("FAIL rand_err[%0d] got %b want %b", t, er, eer); end
            vectors++;
            if (wlog_a != exp_a || wlog_d != exp_d) begin
                miscompares++; $display("FAIL rand_writes[%0d] got %0d writes want %0d", t, wlog_a.size(), exp_a.size());
            end
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = 8'($urandom);
            ref_mem[i] = sram[i];
        end
        ref_din = '0;
        ref_err = 1'b0;
        test_reset();
        test_fetch();
        test_store_load();
        test_wrap();
        test_rd_wr_err();
        test_reset_mid_write();
        do_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
